// File: rtl/error_axis_sequencer.sv
// Registered pose-error sequencer: aligns Y, then X, then Z, with settle counting and hysteresis regression.
// Optional ERRSEQ_PROP_EN selects a saturated proportional command magnitude instead of fixed SPEED.
module error_axis_sequencer #(
  parameter int                 N_WIDTH       = 17,
  parameter int                 Q_WIDTH       = 8,
  parameter logic [N_WIDTH-2:0] TH_Y          = 16'h0014,
  parameter logic [N_WIDTH-2:0] TH_X          = 16'h0014,
  parameter logic [N_WIDTH-2:0] TH_Z          = 16'h0A00,
  parameter logic [N_WIDTH-2:0] HYST          = 16'h0008,
  parameter logic [N_WIDTH-2:0] SPEED         = 16'h0060,
  parameter int                 SETTLE_CYCLES = 4,
  parameter int                 CNT_W         = 3
) (
  input  logic               ERRSEQ_CLOCK_50,
  input  logic               ERRSEQ_RESET_InLow,
  input  logic               ERRSEQ_ENABLE_In,
  input  logic               ERRSEQ_VALID_In,
  input  logic [N_WIDTH-1:0] ERRSEQ_X_InBus,
  input  logic [N_WIDTH-1:0] ERRSEQ_Y_InBus,
  input  logic [N_WIDTH-1:0] ERRSEQ_Z_InBus,
  output logic [N_WIDTH-1:0] ERRSEQ_VX_OutBus,
  output logic [N_WIDTH-1:0] ERRSEQ_VY_OutBus,
  output logic [N_WIDTH-1:0] ERRSEQ_WZ_OutBus,
  output logic               ERRSEQ_VEL_VALID_Out,
  output logic               ERRSEQ_DONE_Out,
  output logic [2:0]         ERRSEQ_STATE_OutBus
);

  localparam int M = N_WIDTH - 1;
  localparam logic [M-1:0]     FAR_Y      = TH_Y + HYST;
  localparam logic [M-1:0]     FAR_X      = TH_X + HYST;
  localparam logic [M-1:0]     FAR_Z      = TH_Z + HYST;
  localparam logic [CNT_W-1:0] SETTLE_CNT = CNT_W'(SETTLE_CYCLES);

  if (SETTLE_CYCLES < 1 || (1 << CNT_W) <= SETTLE_CYCLES || Q_WIDTH >= N_WIDTH) begin : g_param_check
    $error("error_axis_sequencer: inconsistent SETTLE_CYCLES/CNT_W/Q_WIDTH");
  end

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ALIGN_Y = 3'd1,
    ALIGN_X = 3'd2,
    ALIGN_Z = 3'd3,
    DONE    = 3'd4
  } state_t;

  state_t             state, state_nx;
  logic [CNT_W-1:0]   cnt, cnt_nx, cnt_inc;
  logic [N_WIDTH-1:0] vx, vy, wz, vx_nx, vy_nx, wz_nx;
  logic               pulse, pulse_nx;

  logic [M-1:0]       mag_x, mag_y, mag_z;
  logic [M-1:0]       amt_x, amt_y, amt_z;
  logic               oob_x, oob_y, oob_z;
  logic               far_x, far_y, far_z;
  logic               settled;
  logic [N_WIDTH-1:0] cmd_x, cmd_y, cmd_z;

  assign mag_x = ERRSEQ_X_InBus[M-1:0];
  assign mag_y = ERRSEQ_Y_InBus[M-1:0];
  assign mag_z = ERRSEQ_Z_InBus[M-1:0];

  assign oob_x = mag_x > TH_X;
  assign oob_y = mag_y > TH_Y;
  assign oob_z = mag_z > TH_Z;
  assign far_x = mag_x > FAR_X;
  assign far_y = mag_y > FAR_Y;
  assign far_z = mag_z > FAR_Z;

`ifdef ERRSEQ_PROP_EN
  assign amt_x = (mag_x < SPEED) ? mag_x : SPEED;
  assign amt_y = (mag_y < SPEED) ? mag_y : SPEED;
  assign amt_z = (mag_z < SPEED) ? mag_z : SPEED;
`else
  assign amt_x = SPEED;
  assign amt_y = SPEED;
  assign amt_z = SPEED;
`endif

  // Lateral command opposes the X error sign; the other axes follow their error sign.
  assign cmd_y = {ERRSEQ_Y_InBus[N_WIDTH-1], amt_y};
  assign cmd_x = {~ERRSEQ_X_InBus[N_WIDTH-1], amt_x};
  assign cmd_z = {ERRSEQ_Z_InBus[N_WIDTH-1], amt_z};

  assign cnt_inc = (cnt == '1) ? cnt : cnt + 1'b1;
  assign settled = (cnt_inc == SETTLE_CNT);

  always_ff @(posedge ERRSEQ_CLOCK_50 or negedge ERRSEQ_RESET_InLow) begin
    if (!ERRSEQ_RESET_InLow) begin
      state <= IDLE;
      cnt   <= '0;
      vx    <= '0;
      vy    <= '0;
      wz    <= '0;
      pulse <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      vx    <= vx_nx;
      vy    <= vy_nx;
      wz    <= wz_nx;
      pulse <= pulse_nx;
    end
  end

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    vx_nx    = vx;
    vy_nx    = vy;
    wz_nx    = wz;
    pulse_nx = 1'b0;
    if (!ERRSEQ_ENABLE_In) begin
      state_nx = IDLE;
      cnt_nx   = '0;
      vx_nx    = '0;
      vy_nx    = '0;
      wz_nx    = '0;
    end else if (state == IDLE) begin
      state_nx = ALIGN_Y;
      cnt_nx   = '0;
      vx_nx    = '0;
      vy_nx    = '0;
      wz_nx    = '0;
    end else if (ERRSEQ_VALID_In) begin
      pulse_nx = 1'b1;
      cnt_nx   = '0;
      vx_nx    = '0;
      vy_nx    = '0;
      wz_nx    = '0;
      case (state)
        ALIGN_Y: begin
          if (oob_y)        vx_nx    = cmd_y;
          else if (settled) state_nx = ALIGN_X;
          else              cnt_nx   = cnt_inc;
        end
        ALIGN_X: begin
          if (far_y) begin
            state_nx = ALIGN_Y;
            vx_nx    = cmd_y;
          end else if (oob_x) vy_nx    = cmd_x;
          else if (settled)   state_nx = ALIGN_Z;
          else                cnt_nx   = cnt_inc;
        end
        ALIGN_Z: begin
          if (far_y) begin
            state_nx = ALIGN_Y;
            vx_nx    = cmd_y;
          end else if (far_x) begin
            state_nx = ALIGN_X;
            vy_nx    = cmd_x;
          end else if (oob_z) wz_nx    = cmd_z;
          else if (settled)   state_nx = DONE;
          else                cnt_nx   = cnt_inc;
        end
        DONE: begin
          if (far_y) begin
            state_nx = ALIGN_Y;
            vx_nx    = cmd_y;
          end else if (far_x) begin
            state_nx = ALIGN_X;
            vy_nx    = cmd_x;
          end else if (far_z) begin
            state_nx = ALIGN_Z;
            wz_nx    = cmd_z;
          end
        end
        default: state_nx = IDLE;
      endcase
    end
  end

  assign ERRSEQ_VX_OutBus     = vx;
  assign ERRSEQ_VY_OutBus     = vy;
  assign ERRSEQ_WZ_OutBus     = wz;
  assign ERRSEQ_VEL_VALID_Out = pulse;
  assign ERRSEQ_DONE_Out      = (state == DONE);
  assign ERRSEQ_STATE_OutBus  = state;

endmodule

// File: tb/tb_error_axis_sequencer.sv
// Scoreboard bench for error_axis_sequencer: directed scenarios then randomized errors against a phase/axis model.
module tb_error_axis_sequencer;

  localparam int SPEED  = 'h60;
  localparam int HYST   = 'h08;
  localparam int SETTLE = 4;

`ifdef ERRSEQ_PROP_EN
  localparam int C30 = 'h30, C40 = 'h40, C1D = 'h1D, C20 = 'h20;
`else
  localparam int C30 = 'h60, C40 = 'h60, C1D = 'h60, C20 = 'h60;
`endif

  logic        clk = 1'b0;
  logic        rst_n, en, valid;
  logic [16:0] x, y, z, vx, vy, wz;
  logic        vel_valid, done;
  logic [2:0]  st;

  int errors = 0;
  int checks = 0;

  error_axis_sequencer dut (
    .ERRSEQ_CLOCK_50      (clk),
    .ERRSEQ_RESET_InLow   (rst_n),
    .ERRSEQ_ENABLE_In     (en),
    .ERRSEQ_VALID_In      (valid),
    .ERRSEQ_X_InBus       (x),
    .ERRSEQ_Y_InBus       (y),
    .ERRSEQ_Z_InBus       (z),
    .ERRSEQ_VX_OutBus     (vx),
    .ERRSEQ_VY_OutBus     (vy),
    .ERRSEQ_WZ_OutBus     (wz),
    .ERRSEQ_VEL_VALID_Out (vel_valid),
    .ERRSEQ_DONE_Out      (done),
    .ERRSEQ_STATE_OutBus  (st)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        pulse;
    logic [16:0] vx, vy, wz;
    logic [2:0]  st;
  } exp_t;
  exp_t q[$];

  // Model: phase 0 idle, 1..3 = axis (Y,X,Z) being aligned, 4 done; m_out index = command for axis.
  int          m_phase, m_cnt;
  logic        m_pulse;
  logic [16:0] m_out[3];

  function automatic int th_of(input int a);
    if (a == 2) return 'h0A00;
    return 'h0014;
  endfunction

  function automatic logic [16:0] m_cmd(input int a, input logic [16:0] e);
    int   amt = SPEED;
    logic s   = e[16];
`ifdef ERRSEQ_PROP_EN
    if (int'(e[15:0]) < SPEED) amt = int'(e[15:0]);
`endif
    if (a == 1) s = ~s;
    return {s, 16'(amt)};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 3; i++) m_out[i] = '0;
  endtask

  task automatic model_reset();
    m_phase = 0;
    m_cnt   = 0;
    m_pulse = 1'b0;
    model_clear();
  endtask

  task automatic model_step(input logic en_i, input logic v_i, input logic [16:0] ey, ex, ez);
    logic [16:0] e[3];
    int tgt, lim, a;
    e[0] = ey; e[1] = ex; e[2] = ez;
    m_pulse = 1'b0;
    if (!en_i) begin
      m_phase = 0; m_cnt = 0; model_clear();
    end else if (m_phase == 0) begin
      m_phase = 1; m_cnt = 0; model_clear();
    end else if (v_i) begin
      m_pulse = 1'b1;
      model_clear();
      tgt = -1;
      lim = (m_phase == 4) ? 3 : m_phase - 1;
      for (int i = 0; i < lim; i++)
        if (tgt < 0 && int'(e[i][15:0]) > th_of(i) + HYST) tgt = i;
      if (tgt >= 0) begin
        m_phase = tgt + 1;
        m_cnt = 0;
        m_out[tgt] = m_cmd(tgt, e[tgt]);
      end else if (m_phase != 4) begin
        a = m_phase - 1;
        if (int'(e[a][15:0]) > th_of(a)) begin
          m_out[a] = m_cmd(a, e[a]);
          m_cnt = 0;
        end else begin
          m_cnt++;
          if (m_cnt == SETTLE) begin
            m_phase++;
            m_cnt = 0;
          end
        end
      end
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h want 0x%0h", name, act, exp);
    end
  endtask

  // Called at a falling edge; the outcome is visible after the next rising edge.
  task automatic step(input logic en_i, input logic v_i, input logic [16:0] ex, ey, ez);
    exp_t r;
    en = en_i; valid = v_i; x = ex; y = ey; z = ez;
    model_step(en_i, v_i, ey, ex, ez);
    r.pulse = m_pulse;
    r.vx    = m_out[0];
    r.vy    = m_out[1];
    r.wz    = m_out[2];
    r.st    = 3'(m_phase);
    q.push_back(r);
    @(negedge clk);
  endtask

  task automatic check_all_zero(input string name);
    check({name, "_vx"}, int'(vx), 0);
    check({name, "_vy"}, int'(vy), 0);
    check({name, "_wz"}, int'(wz), 0);
    check({name, "_pulse"}, int'(vel_valid), 0);
    check({name, "_done"}, int'(done), 0);
  endtask

  function automatic logic [16:0] rnd_err(input int t);
    int unsigned k = $urandom_range(0, 11);
    int m;
    if (k < 7)       m = int'($urandom_range(0, t));
    else if (k == 7) m = t + 1;
    else if (k == 8) m = t + HYST;
    else if (k == 9) m = t + HYST + 1;
    else             m = int'($urandom_range(0, 'hFFFF));
    return {1'($urandom_range(0, 1)), 16'(m)};
  endfunction

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({vel_valid, vx, vy, wz, st, done} !== {e.pulse, e.vx, e.vy, e.wz, e.st, e.st == 3'd4}) begin
          errors++;
          $display("FAIL scoreboard t=%0t: got pulse=%0b vx=%05h vy=%05h wz=%05h st=%0d done=%0b want pulse=%0b vx=%05h vy=%05h wz=%05h st=%0d",
                   $time, vel_valid, vx, vy, wz, st, done, e.pulse, e.vx, e.vy, e.wz, e.st);
        end
      end
    end
  end

  initial begin : driver
    rst_n = 1'b0; en = 1'b1; valid = 1'b1; x = '0; y = 17'h00030; z = '0;
    model_reset();
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    check("reset_state", int'(st), 0);
    valid = 1'b0;
    rst_n = 1'b1;
    check("release_idle", int'(st), 0);

    step(1, 1, 17'h0, 17'h00030, 17'h0);
    check("enter_align_y", int'(st), 1);
    check("ignored_sample_pulse", int'(vel_valid), 0);
    step(1, 1, 17'h0, 17'h00030, 17'h0);
    check("y_pos_vx", int'(vx), C30);
    check("y_pos_pulse", int'(vel_valid), 1);
    step(1, 0, 17'h0, 17'h0, 17'h0);
    check("hold_vx", int'(vx), C30);
    check("hold_pulse", int'(vel_valid), 0);
    step(1, 1, 17'h0, 17'h10030, 17'h0);
    check("y_neg_vx", int'(vx), 'h10000 | C30);
    repeat (3) step(1, 1, 17'h0, 17'h00010, 17'h0);
    check("y_settle3_state", int'(st), 1);
    check("y_settle3_vx", int'(vx), 0);
    step(1, 1, 17'h0, 17'h00010, 17'h0);
    check("y_settle4_state", int'(st), 2);
    step(1, 1, 17'h00040, 17'h0, 17'h0);
    check("x_pos_vy", int'(vy), 'h10000 | C40);
    step(1, 1, 17'h0, 17'h0001A, 17'h0);
    check("hyst_band_state", int'(st), 2);
    step(1, 1, 17'h0, 17'h0001D, 17'h0);
    check("regress_state", int'(st), 1);
    check("regress_vx", int'(vx), C1D);
    repeat (4) step(1, 1, 17'h0, 17'h0, 17'h0);
    repeat (4) step(1, 1, 17'h0, 17'h0, 17'h0);
    check("align_z_state", int'(st), 3);
    step(1, 1, 17'h0, 17'h0, 17'h00B00);
    check("z_pos_wz", int'(wz), 'h60);
    repeat (4) step(1, 1, 17'h0, 17'h0, 17'h00A00);
    check("done_state", int'(st), 4);
    check("done_out", int'(done), 1);
    step(1, 1, 17'h10020, 17'h0, 17'h0);
    check("done_regress_state", int'(st), 2);
    check("done_regress_vy", int'(vy), C20);
    step(0, 1, 17'h0, 17'h00030, 17'h0);
    check("disable_state", int'(st), 0);
    check_all_zero("disable");

    step(1, 0, 17'h0, 17'h0, 17'h0);
    repeat (8) step(1, 1, 17'h0, 17'h0, 17'h0);
    step(1, 1, 17'h0, 17'h0, 17'h00B00);
    check("pre_reset_wz", int'(wz), 'h60);
    valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    check_all_zero("async_reset");
    check("async_reset_state", int'(st), 0);
    model_reset();
    @(negedge clk);
    en = 1'b1;
    rst_n = 1'b1;

`ifdef ERRSEQ_PROP_EN
    step(1, 0, 17'h0, 17'h0, 17'h0);
    step(1, 1, 17'h0, 17'h00020, 17'h0);
    check("prop_vx", int'(vx), 'h20);
    step(1, 1, 17'h0, 17'h00200, 17'h0);
    check("prop_sat_vx", int'(vx), 'h60);
`endif

    for (int i = 0; i < 3000; i++)
      step($urandom_range(0, 99) != 0, $urandom_range(0, 9) < 7,
           rnd_err(th_of(1)), rnd_err(th_of(0)), rnd_err(th_of(2)));

    for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
    if (q.size() > 0) begin
      errors++;
      checks++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
